// File: rtl/med_arbiter.sv
// med_arbiter: two-port arbiter in front of the single-port data memory.
//   Port 0 = core load/store path, port 1 = host/debug loader.
//   The owner keeps the memory while it requests. A burst counter bounds how
//   long the other port waits when both ports request.
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   reqN/weN/addrN/wdataN   port N request, write enable, address, write data
//   gntN                    port N access accepted this cycle (combinational)
//   rvalidN/rdataN          port N registered read return, one cycle after gnt
//   mem_we/mem_addr/mem_din memory drive from the granted port (port 0 when idle)
//   mem_dout                memory read data, combinational from mem_addr
module med_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  typedef enum logic {
    OWN_P0 = 1'b0,
    OWN_P1 = 1'b1
  } owner_e;

  owner_e            r_owner;
  logic [3:0]        r_burst_cnt;
  logic              r_rvalid0;
  logic              r_rvalid1;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  logic w_gnt0;
  logic w_gnt1;
  logic w_pick1;

  // Under contention the owner keeps the memory until the burst limit is hit.
  always_comb begin
    w_gnt0  = 1'b0;
    w_gnt1  = 1'b0;
    w_pick1 = 1'b0;
    if (req0 && req1) begin
      if (r_burst_cnt < 4'(MAX_BURST))
        w_pick1 = (r_owner == OWN_P1);
      else
        w_pick1 = (r_owner == OWN_P0);
      w_gnt1 = w_pick1;
      w_gnt0 = ~w_pick1;
    end else begin
      w_gnt0 = req0;
      w_gnt1 = req1;
    end
    // No access may be accepted, and nothing written, while reset is held.
    if (!rst_n) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
  end

  assign gnt0     = w_gnt0;
  assign gnt1     = w_gnt1;
  assign mem_we   = (w_gnt0 & we0) | (w_gnt1 & we1);
  assign mem_addr = w_gnt1 ? addr1  : addr0;
  assign mem_din  = w_gnt1 ? wdata1 : wdata0;

  assign rvalid0 = r_rvalid0;
  assign rvalid1 = r_rvalid1;
  assign rdata0  = r_rdata0;
  assign rdata1  = r_rdata1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner     <= OWN_P0;
      r_burst_cnt <= '0;
      r_rvalid0   <= 1'b0;
      r_rvalid1   <= 1'b0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
    end else begin
      r_rvalid0 <= w_gnt0 & ~we0;
      r_rvalid1 <= w_gnt1 & ~we1;
      if (w_gnt0 && !we0) r_rdata0 <= mem_dout;
      if (w_gnt1 && !we1) r_rdata1 <= mem_dout;

      if (w_gnt0 || w_gnt1) begin
        // w_gnt1 identifies the granted port whenever any grant is active.
        if (w_gnt1 == r_owner) begin
          if (r_burst_cnt != 4'hF) r_burst_cnt <= r_burst_cnt + 4'd1;
        end else begin
          r_owner     <= w_gnt1 ? OWN_P1 : OWN_P0;
          r_burst_cnt <= 4'd1;
        end
      end else begin
        r_burst_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_med_arbiter.sv
module tb_med_arbiter;
  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       req0   = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [7:0] addr0  = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic       gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [7:0] rdata0, rdata1, mem_addr, mem_din, mem_dout;

  // Memory environment: combinational read, write at the clock edge.
  logic [7:0] ram [256] = '{default: 8'h00};
  assign mem_dout = ram[mem_addr];
  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_din;

  always #5 clk = ~clk;

  med_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: who owns the memory, how many grants in a row it has
  // had, the expected read returns and the expected memory contents.
  int         m_owner, m_streak;
  logic       m_rv0, m_rv1;
  logic [7:0] m_rd0, m_rd1;
  logic [7:0] ref_mem [256] = '{default: 8'h00};

  task automatic model_reset();
    m_owner = 0; m_streak = 0;
    m_rv0 = 1'b0; m_rv1 = 1'b0; m_rd0 = '0; m_rd1 = '0;
  endtask

  // -1 = nobody, else index of the port that wins this cycle.
  function automatic int model_pick(input logic r0, input logic r1);
    if (!r0 && !r1) return -1;
    if (r0 && !r1)  return 0;
    if (!r0 && r1)  return 1;
    return (m_streak < MAX_BURST) ? m_owner : 1 - m_owner;
  endfunction

  // Inputs are already applied; check the combinational side mid-cycle.
  task automatic comb_phase(input string tag, output int g);
    #2;
    g = model_pick(req0, req1);
    chk({tag, " gnt0"}, gnt0, g == 0);
    chk({tag, " gnt1"}, gnt1, g == 1);
    chk({tag, " mem_we"}, mem_we, (g == 0 && we0) || (g == 1 && we1));
    chk({tag, " mem_addr"}, mem_addr, (g == 1) ? addr1 : addr0);
    chk({tag, " mem_din"}, mem_din, (g == 1) ? wdata1 : wdata0);
  endtask

  // Clock edge: advance the model, then check the registered outputs.
  task automatic edge_phase(input string tag, input int g);
    @(posedge clk);
    m_rv0 = (g == 0) && !we0;
    m_rv1 = (g == 1) && !we1;
    if (g == 0) begin
      if (we0) ref_mem[addr0] = wdata0; else m_rd0 = ref_mem[addr0];
    end
    if (g == 1) begin
      if (we1) ref_mem[addr1] = wdata1; else m_rd1 = ref_mem[addr1];
    end
    if (g < 0)              m_streak = 0;
    else if (g == m_owner)  m_streak = (m_streak >= 15) ? 15 : m_streak + 1;
    else begin m_owner = g; m_streak = 1; end
    #1;
    chk({tag, " rvalid0"}, rvalid0, m_rv0);
    chk({tag, " rdata0"},  rdata0,  m_rd0);
    chk({tag, " rvalid1"}, rvalid1, m_rv1);
    chk({tag, " rdata1"},  rdata1,  m_rd1);
  endtask

  // One cycle with a fixed expected winner (-1 none, 0, 1).
  task automatic one_cycle(input string tag, input int exp_g);
    int g;
    comb_phase(tag, g);
    chk({tag, " fixed gnt0"}, gnt0, exp_g == 0);
    chk({tag, " fixed gnt1"}, gnt1, exp_g == 1);
    edge_phase(tag, g);
  endtask

  task automatic set_ports(input logic r0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                           input logic r1, input logic w1, input logic [7:0] a1, input logic [7:0] d1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
  endtask

  task automatic sync_reset();
    rst_n = 1'b0;
    model_reset();
    set_ports(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic r0, w0; logic [7:0] a0, d0;
    logic r1, w1; logic [7:0] a1, d1;
    logic eg0, eg1, emwe; logic [7:0] emaddr;
    logic erv0; logic [7:0] erd0;
    logic erv1; logic [7:0] erd1;
  } vec_t;

  vec_t tbl [7];
  int   lg0, lg1;

  initial begin
    tbl[0] = '{1'b1, 1'b1, 8'h10, 8'h5A, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h10, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[1] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b1, 1'b0, 8'h10, 1'b0, 8'h00, 1'b1, 8'h5A};
    tbl[2] = '{1'b1, 1'b1, 8'h01, 8'h11, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 8'h00, 1'b0, 8'h5A};
    tbl[3] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h02, 8'h22, 1'b0, 1'b1, 1'b1, 8'h02, 1'b0, 8'h00, 1'b0, 8'h5A};
    tbl[4] = '{1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h01, 1'b1, 8'h11, 1'b0, 8'h5A};
    tbl[5] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00, 1'b0, 1'b1, 1'b0, 8'h02, 1'b0, 8'h11, 1'b1, 8'h22};
    tbl[6] = '{1'b0, 1'b0, 8'h33, 8'h44, 1'b0, 1'b0, 8'h55, 8'h66, 1'b0, 1'b0, 1'b0, 8'h33, 1'b0, 8'h11, 1'b0, 8'h22};

    // Reset held while port 0 asks to write: nothing may be accepted.
    model_reset();
    set_ports(1'b1, 1'b1, 8'h10, 8'h5A, 1'b0, 1'b0, 8'h00, 8'h00);
    #12;
    chk("rst gnt0", gnt0, 0);
    chk("rst gnt1", gnt1, 0);
    chk("rst mem_we", mem_we, 0);
    chk("rst rvalid0", rvalid0, 0);
    chk("rst rdata0", rdata0, 0);
    @(posedge clk); #1;
    chk("rst no write", ram[8'h10], 8'h00);
    rst_n = 1'b1;

    // Directed vectors: write, read back, interleaved reads, idle.
    for (int i = 0; i < 7; i++) begin
      int g;
      string t;
      t = $sformatf("row%0d", i);
      set_ports(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0, tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
      comb_phase(t, g);
      chk({t, " tbl gnt0"}, gnt0, tbl[i].eg0);
      chk({t, " tbl gnt1"}, gnt1, tbl[i].eg1);
      chk({t, " tbl mem_we"}, mem_we, tbl[i].emwe);
      chk({t, " tbl mem_addr"}, mem_addr, tbl[i].emaddr);
      edge_phase(t, g);
      chk({t, " tbl rvalid0"}, rvalid0, tbl[i].erv0);
      chk({t, " tbl rdata0"},  rdata0,  tbl[i].erd0);
      chk({t, " tbl rvalid1"}, rvalid1, tbl[i].erv1);
      chk({t, " tbl rdata1"},  rdata1,  tbl[i].erd1);
    end

    // Idle cycle clears the burst: 3 grants, idle, then 4 more before port 1.
    set_ports(1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 1'b0, 8'h06, 8'h00);
    for (int k = 0; k < 3; k++) one_cycle($sformatf("pre%0d", k), 0);
    req0 = 1'b0;
    one_cycle("idle", -1);
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 6; k++) one_cycle($sformatf("burst%0d", k), (k < 4) ? 0 : 1);

    // Saturation: 17 lone grants leave the counter pinned at 15, not wrapped.
    req1 = 1'b0;
    for (int k = 0; k < 17; k++) one_cycle($sformatf("sat%0d", k), 0);
    req1 = 1'b1;
    one_cycle("sat hand-over", 1);

    // Continuous contention from reset: 4 grants each, alternating.
    sync_reset();
    set_ports(1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
    for (int k = 0; k < 16; k++) one_cycle($sformatf("cont%0d", k), ((k / 4) % 2 == 0) ? 0 : 1);

    // Reset dropped between a read grant and its return edge.
    begin
      int g;
      req0 = 1'b0;
      comb_phase("arst grant", g);
      chk("arst pre gnt1", gnt1, 1);
      #1;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("arst gnt1", gnt1, 0);
      chk("arst mem_we", mem_we, 0);
      @(posedge clk); #1;
      chk("arst rvalid1", rvalid1, 0);
      chk("arst rdata1", rdata1, 0);
      chk("arst rdata0", rdata0, 0);
      rst_n = 1'b1;
      req0 = 1'b1;
      one_cycle("arst owner", 0);
    end

    // Randomized traffic against the model; requests held until granted.
    lg0 = -1; lg1 = -1;
    for (int n = 0; n < 400; n++) begin
      int g;
      if (lg0 == 0 || !req0) begin
        req0 = ($urandom_range(0, 9) < 7);
        we0 = 1'($urandom_range(0, 1)); addr0 = 8'($urandom_range(0, 15)); wdata0 = 8'($urandom);
      end else if ($urandom_range(0, 15) == 0) req0 = 1'b0;
      if (lg1 == 1 || !req1) begin
        req1 = ($urandom_range(0, 9) < 7);
        we1 = 1'($urandom_range(0, 1)); addr1 = 8'($urandom_range(0, 15)); wdata1 = 8'($urandom);
      end else if ($urandom_range(0, 15) == 0) req1 = 1'b0;
      comb_phase($sformatf("rnd%0d", n), g);
      edge_phase($sformatf("rnd%0d", n), g);
      lg0 = g; lg1 = g;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
